// File: rtl/recip_nrd_q4_28_pkg.sv
// Fixed-point format constants shared with the 2x2 matrix inverter, plus the
// reciprocal unit's state encoding.
package recip_nrd_q4_28_pkg;

    // Matrix element, determinant and reciprocal formats (integer/fraction bits)
    localparam int IN_I  = 4;
    localparam int IN_F  = 28;
    localparam int DET_I = 4;
    localparam int DET_F = 28;
    localparam int REC_I = 16;
    localparam int REC_F = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ITER = 3'd2,
        ST_FIN  = 3'd3,
        ST_DONE = 3'd4
    } recip_state_e;

    // Two's-complement magnitude as unsigned; the most negative value maps to 2^(W-1).
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/recip_nrd_q4_28.sv
// Sequential 1/det for a signed Q4.28 determinant, result signed Q16.16, radix-2 non-restoring.
// Latency 34 edges from accepted start to ready (2 for zero/saturating det); one request in flight, start ignored while busy.
module recip_nrd_q4_28
    import recip_nrd_q4_28_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DET_F = 28,
    parameter int QW    = 32,
    parameter int Q_F   = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] det_q4_28,
    output logic [QW-1:0] quotient,
    output logic          error,
    output logic          ready,
    output logic          busy
);

    localparam int RW = DW + 2;
    localparam int SH = DET_F + Q_F - QW;
    localparam int CW = $clog2(QW);

    localparam logic [RW-1:0] R_INIT  = {{(RW-1){1'b0}}, 1'b1} << SH;
    localparam logic [DW:0]   OVF_LIM = {{DW{1'b0}}, 1'b1} << (SH + 1);
    localparam logic [QW-1:0] Q_MAX   = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] Q_MIN   = ~Q_MAX + {{(QW-1){1'b0}}, 1'b1};

    recip_state_e   state_q;
    logic [CW-1:0]  cnt_q;
    logic [RW-1:0]  rem_q;
    logic [QW-1:0]  quo_q;
    logic [DW-1:0]  det_q;
    logic [DW-1:0]  mag_q;
    logic           sgn_q;
    logic           zero_q;
    logic           ovf_q;
    logic [QW-1:0]  quotient_q;
    logic           error_q;
    logic           ready_q;
    logic           busy_q;

    logic [DW-1:0]  mag_d;
    logic           zero_d;
    logic           ovf_d;
    logic [RW-1:0]  rem_d;
    logic [QW-1:0]  quo_d;
    logic [QW-1:0]  quotient_d;

    always_comb begin
        mag_d  = '0;
        zero_d = 1'b0;
        ovf_d  = 1'b0;
        if (DW == 32) begin
            mag_d = abs32(det_q);
        end else begin
            mag_d = det_q[DW-1] ? (~det_q + {{(DW-1){1'b0}}, 1'b1}) : det_q;
        end
        zero_d = (mag_d == '0);
        ovf_d  = !zero_d && ({1'b0, mag_d} <= OVF_LIM);
    end

    // One non-restoring step; the dividend bits below the initial remainder are all zero.
    always_comb begin
        rem_d = '0;
        quo_d = '0;
        if (rem_q[RW-1]) begin
            rem_d = (rem_q << 1) + {2'b00, mag_q};
        end else begin
            rem_d = (rem_q << 1) - {2'b00, mag_q};
        end
        quo_d = {quo_q[QW-2:0], ~rem_d[RW-1]};
    end

    always_comb begin
        quotient_d = '0;
        if (zero_q) begin
            quotient_d = '0;
        end else if (ovf_q) begin
            quotient_d = sgn_q ? Q_MIN : Q_MAX;
        end else begin
            quotient_d = sgn_q ? (~quo_q + {{(QW-1){1'b0}}, 1'b1}) : quo_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            det_q      <= '0;
            mag_q      <= '0;
            sgn_q      <= 1'b0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            quotient_q <= '0;
            error_q    <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b0;
                    if (start) begin
                        det_q   <= det_q4_28;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    sgn_q  <= det_q[DW-1];
                    mag_q  <= mag_d;
                    zero_q <= zero_d;
                    ovf_q  <= ovf_d;
                    if (zero_d || ovf_d) begin
                        state_q <= ST_FIN;
                    end else begin
                        rem_q   <= R_INIT;
                        quo_q   <= '0;
                        cnt_q   <= CW'(QW - 1);
                        state_q <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_q == '0) begin
                        state_q <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    quotient_q <= quotient_d;
                    error_q    <= zero_q || ovf_q;
                    ready_q    <= 1'b1;
                    state_q    <= ST_DONE;
                end
                ST_DONE: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign quotient = quotient_q;
    assign error    = error_q;
    assign ready    = ready_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_recip_nrd_q4_28.sv
// Scoreboard bench for recip_nrd_q4_28: expected results are queued at request time and popped on ready.
module tb_recip_nrd_q4_28;

    typedef struct packed {
        logic [31:0] q;
        logic        e;
        logic [7:0]  lat;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] det_q4_28;
    logic [31:0] quotient;
    logic        error;
    logic        ready;
    logic        busy;

    int   checks;
    int   errors;
    exp_t sb[$];

    recip_nrd_q4_28 dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .det_q4_28 (det_q4_28),
        .quotient  (quotient),
        .error     (error),
        .ready     (ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: integer division of 2^44, truncated toward zero.
    function automatic exp_t model(input logic [31:0] det);
        exp_t        r;
        logic [31:0] mag;
        logic [63:0] qq;
        mag = det[31] ? (~det + 32'd1) : det;
        if (mag == 32'd0) begin
            r.q = 32'd0; r.e = 1'b1; r.lat = 8'd2;
        end else if (mag <= 32'd8192) begin
            r.q = det[31] ? 32'h8000_0001 : 32'h7FFF_FFFF; r.e = 1'b1; r.lat = 8'd2;
        end else begin
            qq  = (64'd1 << 44) / {32'd0, mag};
            r.q = det[31] ? (~qq[31:0] + 32'd1) : qq[31:0];
            r.e = 1'b0; r.lat = 8'd34;
        end
        return r;
    endfunction

    task automatic issue(input logic [31:0] det, input exp_t exp,
                         output logic [31:0] q, output logic e, output int lat,
                         output logic busy_ok, output logic drop_ok);
        sb.push_back(exp);
        @(negedge clk);
        det_q4_28 = det;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        det_q4_28 = $urandom;
        lat       = 0;
        busy_ok   = 1'b1;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (!busy) busy_ok = 1'b0;
        end while (!ready && lat < 100);
        q = quotient;
        e = error;
        @(posedge clk);
        #1;
        drop_ok = !ready && !busy;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        start     = 1'b0;
        det_q4_28 = 32'h1000_0000;
        repeat (3) @(posedge clk);
        #1;
        checks += 4;
        if (quotient !== 32'd0) begin errors++; $display("FAIL reset_quotient got %h want 0", quotient); end
        if (error !== 1'b0)     begin errors++; $display("FAIL reset_error got %b want 0", error); end
        if (ready !== 1'b0)     begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_table();
        logic [31:0] dets [9];
        exp_t        exps [9];
        logic [31:0] q;
        logic        e, bok, dok;
        int          lat;
        exp_t        x;
        dets[0] = 32'h1000_0000; exps[0] = '{32'h0001_0000, 1'b0, 8'd34};
        dets[1] = 32'hE000_0000; exps[1] = '{32'hFFFF_8000, 1'b0, 8'd34};
        dets[2] = 32'h3000_0000; exps[2] = '{32'h0000_5555, 1'b0, 8'd34};
        dets[3] = 32'h0000_4000; exps[3] = '{32'h4000_0000, 1'b0, 8'd34};
        dets[4] = 32'hFFFF_C000; exps[4] = '{32'hC000_0000, 1'b0, 8'd34};
        dets[5] = 32'h8000_0000; exps[5] = '{32'hFFFF_E000, 1'b0, 8'd34};
        dets[6] = 32'h0000_0000; exps[6] = '{32'h0000_0000, 1'b1, 8'd2};
        dets[7] = 32'h0000_1000; exps[7] = '{32'h7FFF_FFFF, 1'b1, 8'd2};
        dets[8] = 32'hFFFF_F000; exps[8] = '{32'h8000_0001, 1'b1, 8'd2};
        for (int i = 0; i < 9; i++) begin
            issue(dets[i], exps[i], q, e, lat, bok, dok);
            x = sb.pop_front();
            checks += 5;
            if (q !== x.q) begin errors++; $display("FAIL table_quotient det=%h got %h want %h", dets[i], q, x.q); end
            if (e !== x.e) begin errors++; $display("FAIL table_error det=%h got %b want %b", dets[i], e, x.e); end
            if (lat != int'(x.lat)) begin errors++; $display("FAIL table_latency det=%h got %0d want %0d", dets[i], lat, x.lat); end
            if (bok !== 1'b1) begin errors++; $display("FAIL table_busy det=%h busy dropped before ready", dets[i]); end
            if (dok !== 1'b1) begin errors++; $display("FAIL table_pulse det=%h ready/busy still high after DONE", dets[i]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] det, q;
        logic        e, bok, dok;
        int          lat;
        exp_t        x;
        for (int i = 0; i < 12; i++) begin
            det = $urandom;
            if (i % 4 == 1) det = det >> 16;
            if (i % 4 == 3) det = 32'hFFFF_FFFF - ($urandom & 32'h0000_3FFF);
            issue(det, model(det), q, e, lat, bok, dok);
            x = sb.pop_front();
            checks += 3;
            if (q !== x.q) begin errors++; $display("FAIL random_quotient det=%h got %h want %h", det, q, x.q); end
            if (e !== x.e) begin errors++; $display("FAIL random_error det=%h got %b want %b", det, e, x.e); end
            if (lat != int'(x.lat)) begin errors++; $display("FAIL random_latency det=%h got %0d want %0d", det, lat, x.lat); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q;
        logic        e, bok, dok;
        int          lat;
        exp_t        x;
        sb.push_back('{32'hFFFF_8000, 1'b0, 8'd34});
        sb.push_back('{32'h0000_4000, 1'b0, 8'd35});
        @(negedge clk);
        det_q4_28 = 32'hE000_0000;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        do begin @(posedge clk); #1; lat++; end while (!ready && lat < 100);
        x = sb.pop_front();
        checks += 2;
        if (quotient !== x.q) begin errors++; $display("FAIL b2b_first got %h want %h", quotient, x.q); end
        if (lat != int'(x.lat)) begin errors++; $display("FAIL b2b_first_latency got %0d want %0d", lat, x.lat); end
        // Held from the DONE cycle: the DONE edge must not accept it, the following IDLE edge must.
        start     = 1'b1;
        det_q4_28 = 32'h4000_0000;
        @(posedge clk);
        #1;
        lat = 1;
        @(posedge clk);
        #1;
        start = 1'b0;
        do begin @(posedge clk); #1; lat++; end while (!ready && lat < 100);
        q = quotient;
        e = error;
        x = sb.pop_front();
        checks += 3;
        if (q !== x.q) begin errors++; $display("FAIL b2b_second got %h want %h", q, x.q); end
        if (e !== x.e) begin errors++; $display("FAIL b2b_second_error got %b want %b", e, x.e); end
        if (lat != int'(x.lat)) begin errors++; $display("FAIL b2b_second_latency got %0d want %0d", lat, x.lat); end
        bok = 1'b1; dok = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_ignored_start();
        int   lat, extra;
        exp_t x;
        sb.push_back('{32'h0000_5555, 1'b0, 8'd34});
        @(negedge clk);
        det_q4_28 = 32'h3000_0000;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        lat       = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            start = (lat == 10);
            if (start) det_q4_28 = 32'h1000_0000;
        end while (!ready && lat < 100);
        start = 1'b0;
        x = sb.pop_front();
        checks += 3;
        if (quotient !== x.q) begin errors++; $display("FAIL ignored_quotient got %h want %h", quotient, x.q); end
        if (lat != int'(x.lat)) begin errors++; $display("FAIL ignored_latency got %0d want %0d", lat, x.lat); end
        extra = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready) extra++;
        end
        if (extra != 0) begin errors++; $display("FAIL ignored_extra_ready got %0d pulses want 0", extra); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] q;
        logic        e, bok, dok;
        int          lat, stray;
        exp_t        x;
        sb.push_back('{32'h0001_0000, 1'b0, 8'd34});
        @(negedge clk);
        det_q4_28 = 32'h1000_0000;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        void'(sb.pop_front());
        checks += 4;
        if (quotient !== 32'd0) begin errors++; $display("FAIL abort_quotient got %h want 0", quotient); end
        if (error !== 1'b0)     begin errors++; $display("FAIL abort_error got %b want 0", error); end
        if (ready !== 1'b0)     begin errors++; $display("FAIL abort_ready got %b want 0", ready); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        stray = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready || busy) stray++;
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL abort_stray got %0d active cycles want 0", stray); end
        issue(32'h1000_0000, '{32'h0001_0000, 1'b0, 8'd34}, q, e, lat, bok, dok);
        x = sb.pop_front();
        checks += 3;
        if (q !== x.q) begin errors++; $display("FAIL abort_recover got %h want %h", q, x.q); end
        if (e !== x.e) begin errors++; $display("FAIL abort_recover_error got %b want %b", e, x.e); end
        if (lat != int'(x.lat)) begin errors++; $display("FAIL abort_recover_latency got %0d want %0d", lat, x.lat); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_table();
        test_random();
        test_back_to_back();
        test_ignored_start();
        test_table();
        test_reset_abort();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
